// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory request/response
// and head-of-queue outputs. master = fetch_queue, slave = decode + memory side.
// Latency/backpressure are defined by the fetch_queue module that uses it.
interface fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc_branch_d;   // redirect target
  logic             pcsrc_d;       // redirect request
  logic             stallf;        // decode cannot take the head
  logic             imem_req;      // fetch request valid
  logic [WIDTH-1:0] imem_addr;     // fetch address
  logic             imem_ready;    // memory accepts request
  logic             imem_rvalid;   // in-order response valid
  logic [WIDTH-1:0] imem_rdata;    // response word
  logic [WIDTH-1:0] instructionf;  // head instruction (0 when empty)
  logic [WIDTH-1:0] pc_plus_4f;    // head PC + step (0 when empty)
  logic             validf;        // head valid

  modport master (
    input  pc_branch_d, pcsrc_d, stallf, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instructionf, pc_plus_4f, validf
  );

  modport slave (
    output pc_branch_d, pcsrc_d, stallf, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instructionf, pc_plus_4f, validf
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: issues in-order imem requests and buffers words with PC+step.
// Latency: accept in cycle N with 1-cycle memory -> validf in cycle N+2; 1 instr/cycle sustained.
// Backpressure: requests only while occupancy+pending < DEPTH; stallf holds the head.
// Ports: clk, reset (async active-high), bus (fetch_queue_if.master):
//   decode side pc_branch_d/pcsrc_d/stallf, memory side imem_req/imem_addr/imem_ready/
//   imem_rvalid/imem_rdata, head outputs instructionf/pc_plus_4f/validf.
module fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(4)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr [DEPTH];
  logic [WIDTH-1:0] r_pcp   [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_occ;
  logic [CW-1:0]    r_pend;
  logic [CW-1:0]    r_disc;

  logic [CW:0]      w_sum;
  logic             w_req;
  logic             w_accept;
  logic             w_resp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [PW-1:0]    w_slot;

  // Credit uses registered counts only; discarded requests still hold credit
  // until their responses drain.
  assign w_sum    = {1'b0, r_occ} + {1'b0, r_pend};
  assign w_req    = !reset && !bus.pcsrc_d && (w_sum < DEPTH_W);
  assign w_accept = w_req && bus.imem_ready;

  // A response with nothing pending is a protocol violation and is ignored.
  assign w_resp   = bus.imem_rvalid && (r_pend != '0);
  assign w_drop   = w_resp && (r_disc != '0);
  assign w_push   = w_resp && (r_disc == '0);

  assign w_valid  = (r_occ != '0);
  assign w_pop    = w_valid && !bus.stallf && !bus.pcsrc_d;

  // Live (non-discarded) pending requests map to consecutive slots after the
  // write pointer, so a new request's PC+step goes just past them.
  assign w_slot   = r_wr_ptr + PW'(r_pend - r_disc);

  assign bus.imem_req     = w_req;
  assign bus.imem_addr    = r_pc;
  assign bus.validf       = w_valid;
  assign bus.instructionf = w_valid ? r_instr[r_rd_ptr] : '0;
  assign bus.pc_plus_4f   = w_valid ? r_pcp[r_rd_ptr]   : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_pend   <= '0;
      r_disc   <= '0;
    end else if (bus.pcsrc_d) begin
      // Redirect beats pop/push/stall; every still-outstanding request
      // becomes a response to drop.
      r_pc     <= bus.pc_branch_d;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      r_pend   <= r_pend - CW'(w_resp);
      r_disc   <= r_pend - CW'(w_resp);
    end else begin
      if (w_accept) begin
        r_pc <= r_pc + PC_STEP;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_occ  <= r_occ + CW'(w_push) - CW'(w_pop);
      r_pend <= r_pend + CW'(w_accept) - CW'(w_resp);
      r_disc <= r_disc - CW'(w_drop);
    end
  end

  // Payload storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (!bus.pcsrc_d) begin
      if (w_accept) begin
        r_pcp[w_slot] <= r_pc + PC_STEP;
      end
      if (w_push) begin
        r_instr[r_wr_ptr] <= bus.imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int W = 32;
  localparam int D = 4;

  typedef struct packed { logic [31:0] instr; logic [31:0] pcp; } ent_t;
  typedef struct packed { logic [31:0] pcp; logic stale; } fl_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(W)) bus ();
  fetch_queue_if #(.WIDTH(W)) bus2 ();

  fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  fetch_queue #(.WIDTH(W), .DEPTH(D), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  int chk_cnt = 0;
  int pass_cnt = 0;

  // reference model
  logic [31:0] m_pc;
  ent_t        m_q[$];
  fl_t         m_fl[$];

  // memory model
  logic [31:0] mem_a[$];
  int          mem_d[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  bit          lat_rand = 0;
  int          ready_pct = 100;
  logic        mem_rvalid = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_rdata = '0;

  // decode-side stimulus
  logic        st_stall = 1'b0;
  logic        st_pcsrc = 1'b0;
  logic [31:0] st_tgt = '0;

  // samples of the current cycle
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pcp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_q.delete();
    m_fl.delete();
  endtask

  // One clock cycle: drive, compare against model, advance model and memory.
  task automatic cycle();
    logic        e_req, e_valid, resp, acc, pop;
    logic [31:0] e_instr, e_pcp;
    fl_t         f;
    int          due;
    bus.stallf      = st_stall;
    bus.pcsrc_d     = st_pcsrc;
    bus.pc_branch_d = st_tgt;
    bus.imem_ready  = mem_ready;
    bus.imem_rvalid = mem_rvalid;
    bus.imem_rdata  = mem_rdata;
    #1;
    s_req = bus.imem_req;  s_addr = bus.imem_addr;  s_valid = bus.validf;
    s_instr = bus.instructionf;  s_pcp = bus.pc_plus_4f;

    e_req   = !reset && !st_pcsrc && ((m_q.size() + m_fl.size()) < D);
    e_valid = (m_q.size() != 0);
    e_instr = e_valid ? m_q[0].instr : 32'h0;
    e_pcp   = e_valid ? m_q[0].pcp   : 32'h0;
    chk("imem_req",     {31'b0, s_req},   {31'b0, e_req});
    chk("imem_addr",    s_addr,           m_pc);
    chk("validf",       {31'b0, s_valid}, {31'b0, e_valid});
    chk("instructionf", s_instr,          e_instr);
    chk("pc_plus_4f",   s_pcp,            e_pcp);

    if (reset) begin
      model_reset();
    end else begin
      resp = mem_rvalid && (m_fl.size() != 0);
      acc  = e_req && mem_ready;
      pop  = e_valid && !st_stall && !st_pcsrc;
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        f = m_fl.pop_front();
        if (!f.stale && !st_pcsrc) m_q.push_back({mem_rdata, f.pcp});
      end
      if (st_pcsrc) begin
        m_q.delete();
        foreach (m_fl[i]) m_fl[i].stale = 1'b1;
        m_pc = st_tgt;
      end else if (acc) begin
        m_fl.push_back({m_pc + 32'd4, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    if (!reset && s_req && mem_ready) begin
      due = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_a.push_back(s_addr);
      mem_d.push_back(due);
    end
    cyc++;
    if (mem_a.size() != 0 && mem_d[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_a.pop_front() | 32'hA000_0000;
      void'(mem_d.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
    mem_ready = ($urandom_range(0, 99) < ready_pct);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] dl_i[$];
    logic [31:0] dl_p[$];
    int          dl_c[$];
    bit          found;
    logic        p_vld;
    logic [31:0] p_addr;

    bus2.stallf = 1'b0;  bus2.pcsrc_d = 1'b0;  bus2.pc_branch_d = '0;
    bus2.imem_ready = 1'b0;  bus2.imem_rvalid = 1'b0;  bus2.imem_rdata = '0;
    model_reset();
    @(negedge clk);

    // reset state
    cycle();
    cycle();
    reset = 1'b0;

    // fill under stall: addresses 0,4,8,C, first head two cycles after first accept
    st_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i < 4) begin
        chk("fill_addr", s_addr, 32'(4 * i));
        chk("fill_req", {31'b0, s_req}, 32'd1);
      end
      if (i < 2) chk("fill_early_valid", {31'b0, s_valid}, 32'd0);
      if (i == 2) begin
        chk("first_instr", s_instr, 32'hA000_0000);
        chk("first_pcp", s_pcp, 32'd4);
      end
      if (i == 9) chk("full_req_low", {31'b0, s_req}, 32'd0);
    end

    // release: 0x0..0x1C delivered in order, one per cycle
    st_stall = 1'b0;
    for (int i = 0; i < 20 && dl_i.size() < 8; i++) begin
      cycle();
      if (s_valid && !st_stall && !st_pcsrc) begin
        dl_i.push_back(s_instr);  dl_p.push_back(s_pcp);  dl_c.push_back(i);
      end
    end
    chk("drain_count", dl_i.size(), 32'd8);
    if (dl_i.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("drain_instr", dl_i[k], 32'hA000_0000 | 32'(4 * k));
        chk("drain_pcp", dl_p[k], 32'(4 * k + 4));
      end
      chk("drain_span", 32'(dl_c[7] - dl_c[0]), 32'd7);
    end

    // redirect with latency 3 and >=2 requests in flight
    lat = 3;
    for (int i = 0; i < 6; i++) cycle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_fl.size() >= 2) found = 1;
      else cycle();
    end
    chk("redir3_inflight", {31'b0, found}, 32'd1);
    st_pcsrc = 1'b1;  st_tgt = 32'h100;
    cycle();
    st_pcsrc = 1'b0;
    cycle();
    chk("redir3_valid_next", {31'b0, s_valid}, 32'd0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (s_valid) begin
        found = 1;
        chk("redir3_instr", s_instr, 32'hA000_0100);
        chk("redir3_pcp", s_pcp, 32'h104);
      end else cycle();
    end
    chk("redir3_delivered", {31'b0, found}, 32'd1);

    // redirect coincident with a response
    lat = 1;
    for (int i = 0; i < 4; i++) cycle();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_rvalid && s_valid) found = 1;
      else cycle();
    end
    chk("redir_rv_setup", {31'b0, found}, 32'd1);
    st_pcsrc = 1'b1;  st_tgt = 32'h200;
    cycle();
    st_pcsrc = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (s_valid) begin
        found = 1;
        chk("redir_rv_instr", s_instr, 32'hA000_0200);
        chk("redir_rv_pcp", s_pcp, 32'h204);
      end
    end
    chk("redir_rv_delivered", {31'b0, found}, 32'd1);

    // randomized traffic
    lat_rand = 1;  ready_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      st_stall = ($urandom_range(0, 9) < 3);
      st_pcsrc = ($urandom_range(0, 19) == 0);
      st_tgt   = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end

    // reset mid-operation with 3 queued and 1 pending
    lat_rand = 0;  lat = 2;  ready_pct = 100;
    st_stall = 1'b1;  st_pcsrc = 1'b1;  st_tgt = 32'h40;
    cycle();
    st_pcsrc = 1'b0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_q.size() == 3 && m_fl.size() == 1) found = 1;
      else cycle();
    end
    chk("rst_setup", {31'b0, found}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_validf", {31'b0, bus.validf}, 32'd0);
    chk("rst_instr", bus.instructionf, 32'd0);
    chk("rst_pcp", bus.pc_plus_4f, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);
    model_reset();
    mem_a.delete();  mem_d.delete();  last_due = cyc;  mem_rvalid = 1'b0;
    @(negedge clk);
    cycle();
    reset = 1'b0;
    st_stall = 1'b0;  lat = 1;
    mem_ready = 1'b0;  mem_rvalid = 1'b1;  mem_rdata = 32'hDEAD_BEEF;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_restart_addr", s_addr, 32'(4 * i));
    end
    chk("rst_first_instr", s_instr, 32'hA000_0000);
    chk("rst_first_pcp", s_pcp, 32'd4);

    // PC wrap on the second instance
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    p_vld = 1'b0;  p_addr = '0;
    for (int i = 0; i < 5; i++) begin
      bus2.imem_ready  = 1'b1;
      bus2.imem_rvalid = p_vld;
      bus2.imem_rdata  = p_addr | 32'hA000_0000;
      #1;
      case (i)
        0: chk("wrap_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
        1: chk("wrap_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
        2: begin
          chk("wrap_addr2", bus2.imem_addr, 32'h0000_0000);
          chk("wrap_instr2", bus2.instructionf, 32'hFFFF_FFF8);
          chk("wrap_pcp2", bus2.pc_plus_4f, 32'hFFFF_FFFC);
        end
        3: begin
          chk("wrap_valid3", {31'b0, bus2.validf}, 32'd1);
          chk("wrap_instr3", bus2.instructionf, 32'hFFFF_FFFC);
          chk("wrap_pcp3", bus2.pc_plus_4f, 32'h0000_0000);
        end
        default: begin
          chk("wrap_instr4", bus2.instructionf, 32'hA000_0000);
          chk("wrap_pcp4", bus2.pc_plus_4f, 32'h0000_0004);
        end
      endcase
      p_vld  = bus2.imem_req;
      p_addr = bus2.imem_addr;
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
